// File: rtl/shift_pkg.sv
// Shared shift-command encodings and receiver output states.
// Also used by the rotator block, so keep the encodings stable.
package shift_pkg;

    localparam logic [1:0] SHIFT_HOLD0 = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD1 = 2'b11;

    typedef enum logic {
        EMPTY,
        PENDING
    } out_state_e;

endpackage

// File: rtl/shift_bit_cnt.sv
// Modulo-DATA_WIDTH bit counter; last flags the final bit position of a word.
module shift_bit_cnt #(
    parameter int DATA_WIDTH = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic inc,
    input  logic clr,
    output logic last
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Double-buffered serial-to-parallel receiver with valid/ready output.
// Define SHIFT_DESER_OVERFLOW_EN to drop (not overwrite) words and flag overflow.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  Left_in,
    input  logic                  Right_in,
    input  logic                  serial_in,
    input  logic                  clr,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  overflow
);

    logic [1:0]            cmd;
    logic                  shift_en;
    logic                  last;
    logic                  done;
    logic [DATA_WIDTH-1:0] shifted;

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    out_state_e            state_q, state_d;

    assign cmd      = {Right_in, Left_in};
    assign shift_en = (cmd == SHIFT_LEFT) || (cmd == SHIFT_RIGHT);
    // clr wins over a coincident shift, so that bit never completes a word
    assign done     = shift_en && last && !clr;

    shift_bit_cnt #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
        .clk  (clk),
        .n_rst(n_rst),
        .inc  (shift_en),
        .clr  (clr),
        .last (last)
    );

    always_comb begin
        shifted = sreg_q;
        case (cmd)
            SHIFT_LEFT:  shifted = {sreg_q[DATA_WIDTH-2:0], serial_in};
            SHIFT_RIGHT: shifted = {serial_in, sreg_q[DATA_WIDTH-1:1]};
            default:     shifted = sreg_q;
        endcase
    end

    always_comb begin
        sreg_d = sreg_q;
        if (clr || done) begin
            sreg_d = '0;
        end else if (shift_en) begin
            sreg_d = shifted;
        end
    end

    logic drop;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (done) begin
                    data_d  = shifted;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (done && data_ready) begin
                    data_d = shifted;
                end else if (done) begin
`ifdef SHIFT_DESER_OVERFLOW_EN
                    drop   = 1'b1;
`else
                    data_d = shifted;
`endif
                end else if (data_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sreg_q  <= '0;
            data_q  <= '0;
            state_q <= EMPTY;
        end else begin
            sreg_q  <= sreg_d;
            data_q  <= data_d;
            state_q <= state_d;
        end
    end

`ifdef SHIFT_DESER_OVERFLOW_EN
    logic ovf_q, ovf_d;

    assign ovf_d = clr ? 1'b0 : (ovf_q || drop);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign overflow    = 1'b0;
`endif

    assign data_out   = data_q;
    assign data_valid = (state_q == PENDING);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (W=4), both overflow build modes.
module tb_shift_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         Left_in, Right_in, serial_in, clr, data_ready;
    logic [W-1:0] data_out;
    logic         data_valid, overflow;

    int n_assert = 0;
    int n_fail   = 0;

    shift_deserializer #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .Left_in   (Left_in),
        .Right_in  (Right_in),
        .serial_in (serial_in),
        .clr       (clr),
        .data_ready(data_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] d,
                           input logic v, input logic o);
        chk({tag, ".data"}, data_out, d);
        chk({tag, ".valid"}, W'(data_valid), W'(v));
        chk({tag, ".ovf"}, W'(overflow), W'(o));
    endtask

    // one clock with the given command; inputs return to idle afterwards
    task automatic step(input logic [1:0] cmd, input logic b,
                        input logic rdy, input logic c);
        {Right_in, Left_in} = cmd;
        serial_in  = b;
        data_ready = rdy;
        clr        = c;
        @(posedge clk);
        #1;
        {Right_in, Left_in} = 2'b00;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        clr        = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        {Right_in, Left_in} = 2'b00;
        serial_in  = 1'b0;
        clr        = 1'b0;
        data_ready = 1'b0;
        #12;
        chk_out("reset", 4'b0000, 1'b0, 1'b0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // left shift 1,0,1,1 -> 1011
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk("left.pre_valid", W'(data_valid), W'(1'b0));
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk_out("left.word", 4'b1011, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        chk_out("left.consume", 4'b1011, 1'b0, 1'b0);

        // right shift 1,0,1,1 -> 1101
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b0);
        chk_out("right.word", 4'b1101, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        chk_out("right.consume", 4'b1101, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        chk_out("right.ready_empty", 4'b1101, 1'b0, 1'b0);

        // hold codes 00 and 11 must not advance the count
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (3) step(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (2) step(2'b11, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk("hold.no_early", W'(data_valid), W'(1'b0));
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk_out("hold.word", 4'b1011, 1'b1, 1'b0);

        // word B = 0110 completes while 1011 is still pending
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
`ifdef SHIFT_DESER_OVERFLOW_EN
        chk_out("ovf.drop", 4'b1011, 1'b1, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        chk_out("ovf.clr", 4'b1011, 1'b1, 1'b0);
`else
        chk_out("ovf.overwrite", 4'b0110, 1'b1, 1'b0);
`endif
        step(2'b00, 1'b0, 1'b1, 1'b0);
        chk("ovf.consume", W'(data_valid), W'(1'b0));

        // clr mid-word discards partial bits and a coincident shift bit
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b1);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0, 1'b0);
        chk("clr.no_early", W'(data_valid), W'(1'b0));
        step(2'b10, 1'b0, 1'b0, 1'b0);
        chk_out("clr.word", 4'b0100, 1'b1, 1'b0);

        // pending word replaced when ready coincides with completion
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk_out("swap.wait", 4'b0100, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1, 1'b0);
        chk_out("swap.word", 4'b0011, 1'b1, 1'b0);

        // stream two words with ready held high
        step(2'b01, 1'b1, 1'b1, 1'b0);
        chk_out("stream.drain", 4'b0011, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b1, 1'b0);
        step(2'b01, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 1'b1, 1'b0);
        chk_out("stream.w0", 4'b1100, 1'b1, 1'b0);
        step(2'b10, 1'b1, 1'b1, 1'b0);
        chk("stream.w0_once", W'(data_valid), W'(1'b0));
        step(2'b10, 1'b0, 1'b1, 1'b0);
        step(2'b10, 1'b0, 1'b1, 1'b0);
        step(2'b10, 1'b1, 1'b1, 1'b0);
        chk_out("stream.w1", 4'b1001, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b1, 1'b0);
        chk("stream.w1_once", W'(data_valid), W'(1'b0));

        // async reset mid-word with a word pending
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk_out("rst.pending", 4'b1111, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk_out("rst.async", 4'b0000, 1'b0, 1'b0);
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        chk("rst.no_residue", W'(data_valid), W'(1'b0));
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk_out("rst.word", 4'b0101, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
